// File: rtl/param_const_stream.sv
// param_const_stream: emits a burst of `count` words on a val/rdy stream,
// either a constant `value` or a ramp starting at `value` and advancing by `step`.
`default_nettype none

module param_const_stream #(
    parameter int nbits = 8,
    parameter int value = 0,
    parameter int step  = 1,
    parameter int count = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             clear,
    output logic [nbits-1:0] out,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             busy,
    output logic             done
);

    localparam int IW = (count > 1) ? $clog2(count) : 1;
    localparam logic [nbits-1:0] FIRST_WORD = nbits'(value);
    localparam logic [nbits-1:0] STEP_WORD  = nbits'(step);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(count - 1);

    generate
        if (count < 1 || nbits < 1) begin : g_bad_params
            $error("param_const_stream: count and nbits must both be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          ramp;

    assign out_val = (state == RUN);
    assign busy    = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            out   <= FIRST_WORD;
            idx   <= '0;
            ramp  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    out <= FIRST_WORD;
                    idx <= '0;
                    // clear takes priority over a simultaneous start
                    if (start && !clear) begin
                        state <= RUN;
                        ramp  <= mode;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state <= IDLE;
                        out   <= FIRST_WORD;
                        idx   <= '0;
                    end else if (out_rdy) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            out   <= FIRST_WORD;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (ramp) begin
                                out <= out + STEP_WORD;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= FIRST_WORD;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_param_const_stream.sv
// Scoreboard bench for param_const_stream: three instances cover the default
// ramp/constant set, an 8-bit wrap-around ramp, and single-word bursts.
`default_nettype none

module tb_param_const_stream;

    logic       clk;
    logic       reset_n;
    logic       start_s [3];
    logic       mode_s  [3];
    logic       clear_s [3];
    logic       rdy_s   [3];
    logic [7:0] out_s   [3];
    logic       val_s   [3];
    logic       busy_s  [3];
    logic       done_s  [3];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int   done_seen [3];
    logic prev_done [3];
    logic prev_hold [3];
    logic [7:0] prev_out [3];

    param_const_stream #(.nbits(8), .value(8'h5A), .step(3), .count(4)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start_s[0]), .mode(mode_s[0]),
        .clear(clear_s[0]), .out(out_s[0]), .out_val(val_s[0]), .out_rdy(rdy_s[0]),
        .busy(busy_s[0]), .done(done_s[0]));

    param_const_stream #(.nbits(8), .value(8'hFE), .step(1), .count(4)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_s[1]), .mode(mode_s[1]),
        .clear(clear_s[1]), .out(out_s[1]), .out_val(val_s[1]), .out_rdy(rdy_s[1]),
        .busy(busy_s[1]), .done(done_s[1]));

    param_const_stream #(.nbits(8), .value(8'h5A), .step(3), .count(1)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start_s[2]), .mode(mode_s[2]),
        .clear(clear_s[2]), .out(out_s[2]), .out_val(val_s[2]), .out_rdy(rdy_s[2]),
        .busy(busy_s[2]), .done(done_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] inst, input logic [7:0] data);
        exp_t e;
        e.inst = inst;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: a word is consumed at the next edge when val && rdy, unless clear or reset
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                prev_hold[k] = 1'b0;
                prev_done[k] = 1'b0;
            end else begin
                if (prev_hold[k] && val_s[k])
                    chk("stall_stable", {24'd0, out_s[k]}, {24'd0, prev_out[k]});
                if (done_s[k]) begin
                    done_seen[k]++;
                    if (prev_done[k]) chk("done_single_cycle", 32'd1, 32'd0);
                end
                prev_done[k] = done_s[k];
                if (val_s[k] && rdy_s[k] && !clear_s[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {24'd0, out_s[k]}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("word_inst", k, {30'd0, e.inst});
                        chk("word_data", {24'd0, out_s[k]}, {24'd0, e.data});
                    end
                end
                prev_hold[k] = val_s[k] && !rdy_s[k] && !clear_s[k];
                prev_out[k]  = out_s[k];
            end
        end
    end

    initial begin
        logic pattern [7];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 0; mode_s[k] = 0; clear_s[k] = 0; rdy_s[k] = 0;
            done_seen[k] = 0; prev_done[k] = 0; prev_hold[k] = 0; prev_out[k] = 0;
        end
        reset_n = 0;
        cyc(3);
        reset_n = 1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("reset_idle", {out_s[0], 5'd0, val_s[0], busy_s[0], done_s[0]},
                {8'h5A, 8'd0});
            cyc(1);
        end

        // Ramp burst
        push(0, 8'h5A); push(0, 8'h5D); push(0, 8'h60); push(0, 8'h63);
        mode_s[0] = 1; start_s[0] = 1; rdy_s[0] = 1;
        cyc(1);
        start_s[0] = 0;
        chk("ramp_first_valid", {31'd0, val_s[0]}, 32'd1);
        cyc(4);
        chk("ramp_done", {out_s[0], 5'd0, val_s[0], busy_s[0], done_s[0]}, {8'h5A, 8'd1});
        cyc(1);
        chk("ramp_done_drop", {31'd0, done_s[0]}, 32'd0);

        // Constant burst with backpressure
        for (int i = 0; i < 4; i++) push(0, 8'h5A);
        mode_s[0] = 0; start_s[0] = 1; rdy_s[0] = 0;
        cyc(1);
        start_s[0] = 0;
        for (int i = 0; i < 7; i++) begin
            rdy_s[0] = pattern[i];
            cyc(1);
            if (i == 5) chk("const_not_done_early", {31'd0, done_s[0]}, 32'd0);
        end
        chk("const_done", {30'd0, val_s[0], done_s[0]}, 32'd1);
        rdy_s[0] = 0;
        cyc(1);

        // Abort with clear (start held alongside), then fresh burst with a mid-burst start
        push(0, 8'h5A); push(0, 8'h5D);
        mode_s[0] = 1; start_s[0] = 1; rdy_s[0] = 1;
        cyc(1);
        start_s[0] = 0;
        cyc(2);
        clear_s[0] = 1; start_s[0] = 1;
        cyc(1);
        clear_s[0] = 0; start_s[0] = 0;
        chk("abort_idle", {out_s[0], 5'd0, val_s[0], busy_s[0], done_s[0]}, {8'h5A, 8'd0});
        cyc(1);
        chk("abort_no_done", {31'd0, done_s[0]}, 32'd0);

        push(0, 8'h5A); push(0, 8'h5D); push(0, 8'h60); push(0, 8'h63);
        mode_s[0] = 1; start_s[0] = 1;
        cyc(1);
        start_s[0] = 0;
        cyc(1);
        start_s[0] = 1; mode_s[0] = 0;
        cyc(1);
        start_s[0] = 0;
        cyc(2);
        chk("fresh_done", {out_s[0], 5'd0, val_s[0], busy_s[0], done_s[0]}, {8'h5A, 8'd1});
        cyc(1);

        // Asynchronous reset after the 2nd word
        push(0, 8'h5A); push(0, 8'h5D);
        mode_s[0] = 1; start_s[0] = 1;
        cyc(1);
        start_s[0] = 0;
        cyc(2);
        #2 reset_n = 0;
        #1 chk("async_reset", {out_s[0], 5'd0, val_s[0], busy_s[0], done_s[0]}, {8'h5A, 8'd0});
        cyc(1);
        reset_n = 1;
        rdy_s[0] = 0;
        cyc(1);
        chk("post_reset_no_done", {30'd0, val_s[0], done_s[0]}, 32'd0);

        // Wrap-around ramp
        push(1, 8'hFE); push(1, 8'hFF); push(1, 8'h00); push(1, 8'h01);
        mode_s[1] = 1; start_s[1] = 1; rdy_s[1] = 1;
        cyc(1);
        start_s[1] = 0;
        cyc(4);
        chk("wrap_done", {out_s[1], 6'd0, val_s[1], done_s[1]}, {8'hFE, 8'd1});
        cyc(1);

        // count=1 back-to-back: restart on the done cycle
        push(2, 8'h5A); push(2, 8'h5A);
        mode_s[2] = 1; start_s[2] = 1; rdy_s[2] = 1;
        cyc(1);
        start_s[2] = 0;
        chk("c1_val_t1", {30'd0, val_s[2], done_s[2]}, 32'd2);
        cyc(1);
        chk("c1_done_t2", {30'd0, val_s[2], done_s[2]}, 32'd1);
        start_s[2] = 1;
        cyc(1);
        start_s[2] = 0;
        chk("c1_val_t3", {30'd0, val_s[2], done_s[2]}, 32'd2);
        cyc(1);
        chk("c1_done_t4", {30'd0, val_s[2], done_s[2]}, 32'd1);
        cyc(2);

        chk("done_count_a", done_seen[0], 32'd3);
        chk("done_count_b", done_seen[1], 32'd1);
        chk("done_count_c", done_seen[2], 32'd2);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
